pipelined_shifter: RTL and testbench
====================================

Name: pipelined_shifter

Overview:
- Parametrised, pipelined barrel shifter. Successor to the 16-bit left/right shifter pair.
- Generalised to any power-of-two width.
- Four modes: logical left, logical right, arithmetic right, rotate right.
- One register per shift level, with a valid/ready elastic handshake on input and output.
- Sits between an operand source and any ALU/datapath consumer that can apply backpressure.

Parameters:
- W, 16, data width; power of two, W >= 4.
- AW, $clog2(W), shift-amount width; derived, not to be overridden.
- LEVELS, $clog2(W), number of shift levels, which is also the number of pipeline registers; derived.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  input transaction present.
- in_ready  output  1  block can accept an input this cycle.
- in_data  input  W  operand.
- in_amt  input  AW  shift amount, 0..W-1.
- in_mode  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result this cycle.
- out_data  output  W  shifted result.

Behaviour:
- Reset (synchronous, active-high):
  - All stage valid bits clear; all stage data, amt, mode and sign registers clear to 0.
  - out_valid=0, out_data=0.
  - in_ready=1 in the first cycle after reset.
- Level k (k=0..LEVELS-1) shifts by 2^k when amt bit k is set, otherwise passes data through. Its result is registered in stage k.
  - amt, mode and the original operand MSB (the sign) travel with the data.
- Fill rules:
  - LSL: fill with 0 from the right.
  - LSR: fill with 0 from the left.
  - ASR: fill with the carried sign bit.
  - ROR: bits wrap from the LSB to the MSB.
- Elastic pipeline:
  - adv[LEVELS-1] = ~v[LEVELS-1] | out_ready.
  - adv[k] = ~v[k] | adv[k+1].
  - in_ready = adv[0].
  - Stage k loads on adv[k]: v[k] <= previous stage valid (in_valid for k=0).
  - Stage k holds data and valid when adv[k]=0.
- Output mapping: out_valid = v[LEVELS-1]; out_data = stage LEVELS-1 data.
- Latency: a transfer accepted at edge t (in_valid & in_ready) produces out_valid=1 after edge t+LEVELS-1. That is LEVELS cycles from acceptance to output when no stall. W=16 gives 4.
- Throughput: 1 result per cycle with out_ready held high.
- Stall: out_valid & ~out_ready freezes the last stage; bubbles in earlier stages still collapse.
  - Up to LEVELS results are held; in_ready falls only when every stage is full and out_ready=0.
  - Results are never dropped, duplicated or reordered.
  - out_data is stable while out_valid=1 and out_ready=0.
- Simultaneous accept and drain with a full pipeline: both occur, occupancy unchanged.
- amt=0: result equals the operand for every mode.
- ASR with a positive operand is identical to LSR.
- Reset mid-operation: all in-flight results discarded; out_valid=0 the cycle after reset is sampled.
- in_valid with in_ready=0: the input is not captured; the source must hold it.

Optional Feature:
- Macro: SHIFTER_ROTATE_EN.
- Defined: mode 11 performs rotate-right with wraparound as above.
- Undefined: no rotate logic is synthesised; mode 11 behaves exactly as LSR (01).

Decomposition:
- Shared package shifter_pkg holds:
  - mode constants MODE_LSL=2'b00, MODE_LSR=2'b01, MODE_ASR=2'b10, MODE_ROR=2'b11;
  - the 2-bit mode typedef.
- One natural sub-module: shift_level.
  - Parameters W and SHIFT (=2^k).
  - Implements the combinational shift for one level plus its stage register and valid/advance logic.
  - Instantiated LEVELS times in a generate loop.

Test Plan:
- Reset: hold reset 2 cycles with in_valid=1 -> out_valid=0, out_data=0 and in_ready=1 after release; nothing emerges.
- LSL, W=16: in_data=0x0001, amt=15, mode=00, accepted at edge t -> out_valid=1 with out_data=0x8000 after edge t+3. Also amt=0, in_data=0xA5C3 -> out_data=0xA5C3.
- Right shifts of 0x8000 by amt=4:
  - mode=10 -> out_data=0xF800.
  - mode=01 -> out_data=0x0800.
- Mode 11, in_data=0x1234, amt=4:
  - with SHIFTER_ROTATE_EN -> out_data=0x4123;
  - without -> out_data=0x0123.
- Backpressure: stream 8 back-to-back inputs, out_ready=0 for cycles 5-7:
  - in_ready drops only when 4 results are held;
  - all 8 results arrive in order with correct values;
  - out_data is stable during the stall.
- Reset mid-stream: assert reset with 3 results in flight -> out_valid=0 the next cycle; the first post-reset input emerges after LEVELS cycles with no stale data.

Source files
------------

// File: rtl/shifter_pkg.sv
// ============================================================================
// Module  : shifter_pkg
// Brief   : Shared mode encodings and mode type for the pipelined shifter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package shifter_pkg;

  typedef logic [1:0] shift_mode_t;

  localparam shift_mode_t MODE_LSL = 2'b00;
  localparam shift_mode_t MODE_LSR = 2'b01;
  localparam shift_mode_t MODE_ASR = 2'b10;
  localparam shift_mode_t MODE_ROR = 2'b11;

endpackage

`default_nettype wire

// File: rtl/shift_level.sv
// ============================================================================
// Module  : shift_level
// Brief   : One barrel-shifter level (shift by SHIFT when its amt bit is set)
//           with its elastic stage register. Rotate gated by SHIFTER_ROTATE_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_level
  import shifter_pkg::*;
#(
  parameter int W     = 16,
  parameter int SHIFT = 1,
  parameter int AW    = $clog2(W)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic          valid_i,
  input  logic [W-1:0]  data_i,
  input  logic [AW-1:0] amt_i,
  input  logic [1:0]    mode_i,
  input  logic          sign_i,
  output logic          valid_o,
  output logic [W-1:0]  data_o,
  output logic [AW-1:0] amt_o,
  output logic [1:0]    mode_o,
  output logic          sign_o
);

  localparam int K = $clog2(SHIFT);

  logic          valid_q;
  logic [W-1:0]  data_q;
  logic [W-1:0]  data_d;
  logic [AW-1:0] amt_q;
  logic [1:0]    mode_q;
  logic          sign_q;

  always_comb begin
    data_d = data_i;
    if (amt_i[K]) begin
      case (shift_mode_t'(mode_i))
        MODE_LSL: data_d = data_i << SHIFT;
        MODE_LSR: data_d = data_i >> SHIFT;
        MODE_ASR: data_d = {{SHIFT{sign_i}}, data_i[W-1:SHIFT]};
`ifdef SHIFTER_ROTATE_EN
        MODE_ROR: data_d = {data_i[SHIFT-1:0], data_i[W-1:SHIFT]};
`else
        MODE_ROR: data_d = data_i >> SHIFT;
`endif
        default:  data_d = data_i;
      endcase
    end
  end

  // The whole stage freezes when load_i is low; a bubble stage always loads.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      amt_q   <= '0;
      mode_q  <= '0;
      sign_q  <= 1'b0;
    end else if (load_i) begin
      valid_q <= valid_i;
      data_q  <= data_d;
      amt_q   <= amt_i;
      mode_q  <= mode_i;
      sign_q  <= sign_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign amt_o   = amt_q;
  assign mode_o  = mode_q;
  assign sign_o  = sign_q;

endmodule

`default_nettype wire

// File: rtl/pipelined_shifter.sv
// ============================================================================
// Module  : pipelined_shifter
// Brief   : Parametrised elastic barrel shifter, one register per shift level.
//           Define SHIFTER_ROTATE_EN to make mode 11 rotate right (else LSR).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pipelined_shifter
  import shifter_pkg::*;
#(
  parameter  int W      = 16,
  localparam int AW     = $clog2(W),
  localparam int LEVELS = $clog2(W)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic [AW-1:0] in_amt,
  input  logic [1:0]    in_mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data
);

  // Index 0 is the pipeline input; index k+1 is the output of level k.
  logic          w_valid [0:LEVELS];
  logic [W-1:0]  w_data  [0:LEVELS];
  logic [AW-1:0] w_amt   [0:LEVELS];
  logic [1:0]    w_mode  [0:LEVELS];
  logic          w_sign  [0:LEVELS];

  logic [LEVELS-1:0] w_vvec;
  logic [LEVELS-1:0] w_adv;

  assign w_valid[0] = in_valid;
  assign w_data[0]  = in_data;
  assign w_amt[0]   = in_amt;
  assign w_mode[0]  = in_mode;
  assign w_sign[0]  = in_data[W-1];

  for (genvar k = 0; k < LEVELS; k++) begin : g_level
    assign w_vvec[k] = w_valid[k+1];
    // Unrolled advance chain: stage k moves unless it and every later stage is full and stalled.
    assign w_adv[k]  = out_ready | ~(&w_vvec[LEVELS-1:k]);

    shift_level #(
      .W     (W),
      .SHIFT (1 << k),
      .AW    (AW)
    ) u_level (
      .clk     (clk),
      .reset   (reset),
      .load_i  (w_adv[k]),
      .valid_i (w_valid[k]),
      .data_i  (w_data[k]),
      .amt_i   (w_amt[k]),
      .mode_i  (w_mode[k]),
      .sign_i  (w_sign[k]),
      .valid_o (w_valid[k+1]),
      .data_o  (w_data[k+1]),
      .amt_o   (w_amt[k+1]),
      .mode_o  (w_mode[k+1]),
      .sign_o  (w_sign[k+1])
    );
  end

  assign in_ready  = w_adv[0];
  assign out_valid = w_valid[LEVELS];
  assign out_data  = w_data[LEVELS];

endmodule

`default_nettype wire

// File: tb/tb_pipelined_shifter.sv
// ============================================================================
// Module  : tb_pipelined_shifter
// Brief   : Directed self-checking bench for pipelined_shifter (W=16).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipelined_shifter;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_amt;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipelined_shifter #(.W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single transfer with exact-latency check; result drains on the following edge.
  task automatic send_one(input string tag, input logic [15:0] d, input logic [3:0] a,
                          input logic [1:0] m, input logic [15:0] exp);
    in_valid = 1'b1; in_data = d; in_amt = a; in_mode = m;
    #1;
    check({tag, "_in_ready"}, {15'd0, in_ready}, 16'd1);
    step();
    in_valid = 1'b0;
    step();
    step();
    check({tag, "_early"}, {15'd0, out_valid}, 16'd0);
    step();
    check({tag, "_valid"}, {15'd0, out_valid}, 16'd1);
    check(tag, out_data, exp);
  endtask

  logic [15:0] bp_in  [0:7];
  logic [15:0] bp_exp [0:7];
  logic [15:0] ror_exp;

  initial begin
    bp_in  = '{16'h1230, 16'h2230, 16'h3230, 16'h4230, 16'h5230, 16'h6230, 16'h7230, 16'h8230};
    bp_exp = '{16'h0123, 16'h0223, 16'h0323, 16'h0423, 16'h0523, 16'h0623, 16'h0723, 16'h0823};
`ifdef SHIFTER_ROTATE_EN
    ror_exp = 16'h4123;
`else
    ror_exp = 16'h0123;
`endif

    // Reset held two cycles with a live input that must not be captured
    reset = 1'b1; in_valid = 1'b1; in_data = 16'hFFFF; in_amt = 4'd0; in_mode = 2'b00;
    out_ready = 1'b1;
    step();
    step();
    check("rst_out_valid", {15'd0, out_valid}, 16'd0);
    check("rst_out_data", out_data, 16'h0000);
    reset = 1'b0; in_valid = 1'b0;
    #1;
    check("rst_in_ready", {15'd0, in_ready}, 16'd1);
    for (int i = 0; i < 5; i++) step();
    check("rst_nothing_out", {15'd0, out_valid}, 16'd0);

    // Directed single transfers
    send_one("lsl_15",    16'h0001, 4'd15, 2'b00, 16'h8000);
    send_one("lsl_0",     16'hA5C3, 4'd0,  2'b00, 16'hA5C3);
    send_one("asr_neg",   16'h8000, 4'd4,  2'b10, 16'hF800);
    send_one("lsr_4",     16'h8000, 4'd4,  2'b01, 16'h0800);
    send_one("mode11_4",  16'h1234, 4'd4,  2'b11, ror_exp);
    send_one("mode11_0",  16'h1234, 4'd0,  2'b11, 16'h1234);
    send_one("asr_pos",   16'h7F00, 4'd3,  2'b10, 16'h0FE0);
    send_one("lsl_4",     16'h1234, 4'd4,  2'b00, 16'h2340);
    send_one("asr_15",    16'hF0F0, 4'd15, 2'b10, 16'hFFFF);
    send_one("lsr_15",    16'hF0F0, 4'd15, 2'b01, 16'h0001);
    step();
    check("idle_after_drain", {15'd0, out_valid}, 16'd0);

    // Backpressure: 8 back-to-back inputs, consumer stalls in cycles 5..7
    begin
      int sent = 0, recv = 0, cyc = 0;
      logic        prev_stall = 1'b0;
      logic [15:0] prev_data  = 16'h0;
      while (recv < 8 && cyc < 60) begin
        in_valid  = (sent < 8);
        in_data   = (sent < 8) ? bp_in[sent] : 16'h0;
        in_amt    = 4'd4;
        in_mode   = 2'b01;
        out_ready = !(cyc >= 5 && cyc <= 7);
        #1;
        check("bp_in_ready", {15'd0, in_ready}, {15'd0, !((sent - recv) == 4 && !out_ready)});
        if (prev_stall) begin
          check("bp_stall_valid", {15'd0, out_valid}, 16'd1);
          check("bp_stall_data", out_data, prev_data);
        end
        if (out_valid && out_ready) begin
          check("bp_data", out_data, bp_exp[recv]);
          recv++;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        if (in_valid && in_ready) sent++;
        step();
        cyc++;
      end
      check("bp_all_received", 16'(recv), 16'd8);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    step();
    check("bp_empty", {15'd0, out_valid}, 16'd0);

    // Reset with three results in flight
    in_amt = 4'd0; in_mode = 2'b00; in_valid = 1'b1;
    in_data = 16'hAAAA; step();
    in_data = 16'hBBBB; step();
    in_data = 16'hCCCC; step();
    in_valid = 1'b0;
    reset = 1'b1;
    step();
    check("midrst_out_valid", {15'd0, out_valid}, 16'd0);
    reset = 1'b0;
    begin
      int stale = 0;
      for (int i = 0; i < 6; i++) begin
        if (out_valid) stale++;
        step();
      end
      check("midrst_no_stale", 16'(stale), 16'd0);
    end
    send_one("post_rst", 16'h5555, 4'd1, 2'b00, 16'hAAAA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
